// File: rtl/exu_bp_update_queue_pkg.sv
// Shared types for the branch-predictor update queue.
// One record per resolved branch, as written to the BTB/BHT.
package exu_bp_update_queue_pkg;

    typedef struct packed {
        logic [31:1] pc;
        logic [31:1] target;
        logic        ataken;
        logic        misp;
        logic [1:0]  hist;
    } bp_upd_pkt_t;

endpackage

// File: rtl/exu_bp_update_queue_ptr.sv
// Wrap-bit queue pointer: increment, load and synchronous reset.
// Load has priority over increment.
module exu_bp_upd_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/exu_bp_update_queue.sv
// Branch-predictor update queue: speculative capture, in-order
// commit, and drain to the predictor write port.
module exu_bp_update_queue
    import exu_bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [30:0] br_pc,
    input  logic        br_ataken,
    input  logic        br_misp,
    input  logic [1:0]  br_hist,
    input  logic [30:0] br_target,
    input  logic        commit,
    input  logic        flush_lower,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [30:0] upd_pc,
    output logic [30:0] upd_target,
    output logic        upd_ataken,
    output logic        upd_misp,
    output logic [1:0]  upd_hist,
    output logic        full,
    output logic        ovf
);

    logic [PTRW:0] wr_ptr;
    logic [PTRW:0] cm_ptr;
    logic [PTRW:0] rd_ptr;
    logic [PTRW:0] cm_next;

    logic deq;
    logic enq;
    logic drop;
    logic cm_inc;

    bp_upd_pkt_t slots [DEPTH];
    bp_upd_pkt_t wr_pkt;
    bp_upd_pkt_t head;

    assign full = (wr_ptr[PTRW] != rd_ptr[PTRW]) &&
                  (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);

    assign upd_valid = (rd_ptr != cm_ptr);
    assign deq       = upd_valid & upd_ready;
    assign enq       = br_valid & ~flush_lower & (~full | deq);
    assign drop      = br_valid & ~flush_lower & full & ~deq;
    assign cm_inc    = commit & (cm_ptr != wr_ptr);

    // Flush rewinds the write pointer to the post-commit boundary.
    assign cm_next = cm_ptr + {{PTRW{1'b0}}, cm_inc};

    exu_bp_upd_ptr #(.W(PTRW + 1)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (enq),
        .load     (flush_lower),
        .load_val (cm_next),
        .ptr      (wr_ptr)
    );

    exu_bp_upd_ptr #(.W(PTRW + 1)) u_cm_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (cm_inc),
        .load     (1'b0),
        .load_val ({(PTRW + 1){1'b0}}),
        .ptr      (cm_ptr)
    );

    exu_bp_upd_ptr #(.W(PTRW + 1)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (deq),
        .load     (1'b0),
        .load_val ({(PTRW + 1){1'b0}}),
        .ptr      (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        wr_pkt        = '0;
        wr_pkt.pc     = br_pc;
        wr_pkt.target = br_target;
        wr_pkt.ataken = br_ataken;
        wr_pkt.misp   = br_misp;
        wr_pkt.hist   = br_hist;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (wr_ptr[PTRW-1:0] == PTRW'(i))) begin
                slots[i] <= wr_pkt;
            end
        end
    end

    assign head       = slots[rd_ptr[PTRW-1:0]];
    assign upd_pc     = head.pc;
    assign upd_target = head.target;
    assign upd_ataken = head.ataken;
    assign upd_misp   = head.misp;
    assign upd_hist   = head.hist;

endmodule

// File: tb/tb_exu_bp_update_queue.sv
// Directed self-checking bench for exu_bp_update_queue.
module tb_exu_bp_update_queue;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [30:0] br_pc;
    logic        br_ataken;
    logic        br_misp;
    logic [1:0]  br_hist;
    logic [30:0] br_target;
    logic        commit;
    logic        flush_lower;
    logic        upd_valid;
    logic        upd_ready;
    logic [30:0] upd_pc;
    logic [30:0] upd_target;
    logic        upd_ataken;
    logic        upd_misp;
    logic [1:0]  upd_hist;
    logic        full;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    exu_bp_update_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .br_ataken   (br_ataken),
        .br_misp     (br_misp),
        .br_hist     (br_hist),
        .br_target   (br_target),
        .commit      (commit),
        .flush_lower (flush_lower),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_ataken  (upd_ataken),
        .upd_misp    (upd_misp),
        .upd_hist    (upd_hist),
        .full        (full),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        br_valid = 1'b0;
        commit = 1'b0;
        flush_lower = 1'b0;
        upd_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drive_br(input logic [30:0] pc);
        br_valid  = 1'b1;
        br_pc     = pc;
        br_target = pc + 31'h200;
        br_ataken = pc[0];
        br_misp   = ~pc[0];
        br_hist   = pc[2:1];
    endtask

    task automatic enq(input logic [30:0] pc);
        drive_br(pc);
        step();
        br_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", upd_valid);
        end
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full got %b want 0", full);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
    endtask

    task automatic test_single;
        do_reset();
        enq(31'h100);
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_spec_hidden got %b want 0", upd_valid);
        end
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h100) begin
            errors++;
            $display("FAIL single_head got v=%b pc=%h want v=1 pc=100",
                     upd_valid, upd_pc);
        end
        checks++;
        if (upd_target !== 31'h300 || upd_ataken !== 1'b0 ||
            upd_misp !== 1'b1 || upd_hist !== 2'b00) begin
            errors++;
            $display("FAIL single_fields got t=%h a=%b m=%b h=%b want 300 0 1 00",
                     upd_target, upd_ataken, upd_misp, upd_hist);
        end
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drained got %b want 0", upd_valid);
        end
    endtask

    task automatic test_full_ovf;
        do_reset();
        for (int i = 0; i < 4; i++) enq(31'h10 + 31'(i));
        checks++;
        if (full !== 1'b1 || upd_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_state got f=%b v=%b o=%b want 1 0 0",
                     full, upd_valid, ovf);
        end
        enq(31'h99);
        checks++;
        if (ovf !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got o=%b f=%b want 1 1", ovf, full);
        end
        commit = 1'b1;
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (upd_valid !== 1'b1 || upd_pc !== 31'h10 + 31'(i)) begin
                errors++;
                $display("FAIL full_drain%0d got v=%b pc=%h want v=1 pc=%h",
                         i, upd_valid, upd_pc, 31'h10 + 31'(i));
            end
        end
        commit = 1'b0;
        step();
        upd_ready = 1'b0;
        checks++;
        if (upd_valid !== 1'b0 || ovf !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_empty got v=%b o=%b f=%b want 0 1 0",
                     upd_valid, ovf, full);
        end
    endtask

    task automatic test_flush;
        do_reset();
        enq(31'h0a);
        enq(31'h0b);
        enq(31'h0c);
        commit = 1'b1;
        step();
        commit = 1'b0;
        drive_br(31'h0d);
        flush_lower = 1'b1;
        step();
        br_valid = 1'b0;
        flush_lower = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h0a) begin
            errors++;
            $display("FAIL flush_keepA got v=%b pc=%h want 1 0a",
                     upd_valid, upd_pc);
        end
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_killed got v=%b pc=%h want v=0",
                     upd_valid, upd_pc);
        end
        enq(31'h0e);
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h0e) begin
            errors++;
            $display("FAIL flush_after got v=%b pc=%h want 1 0e",
                     upd_valid, upd_pc);
        end
    endtask

    task automatic test_commit_flush;
        do_reset();
        enq(31'h2b);
        enq(31'h2c);
        commit = 1'b1;
        flush_lower = 1'b1;
        step();
        commit = 1'b0;
        flush_lower = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h2b) begin
            errors++;
            $display("FAIL cf_headB got v=%b pc=%h want 1 2b",
                     upd_valid, upd_pc);
        end
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cf_killC got v=%b pc=%h want v=0",
                     upd_valid, upd_pc);
        end
    endtask

    task automatic test_full_deq_enq;
        do_reset();
        for (int i = 0; i < 4; i++) enq(31'h40 + 31'(i));
        commit = 1'b1;
        repeat (4) step();
        commit = 1'b0;
        drive_br(31'h55);
        upd_ready = 1'b1;
        step();
        br_valid = 1'b0;
        checks++;
        if (full !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fde_state got f=%b o=%b want 1 0", full, ovf);
        end
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h41) begin
            errors++;
            $display("FAIL fde_head got v=%b pc=%h want 1 41",
                     upd_valid, upd_pc);
        end
        commit = 1'b1;
        step();
        step();
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 31'h55) begin
            errors++;
            $display("FAIL fde_newrec got v=%b pc=%h want 1 55",
                     upd_valid, upd_pc);
        end
        step();
        upd_ready = 1'b0;
        checks++;
        if (upd_valid !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL fde_empty got v=%b f=%b want 0 0",
                     upd_valid, full);
        end
    endtask

    task automatic test_stream_wrap;
        logic [30:0] expq[$];
        int sent;
        int got;
        int cyc;
        do_reset();
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < 20 || expq.size() != 0) && cyc < 200) begin
            br_valid = 1'b0;
            if ((cyc % 2 == 0) && sent < 20) begin
                drive_br(31'h1000 + 31'(sent * 3));
                if (full === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_full got full=1 want 0 at rec %0d", sent);
                end
                expq.push_back(31'h1000 + 31'(sent * 3));
                sent++;
            end
            commit = 1'b1;
            upd_ready = (cyc % 3 != 2) || (sent == 20);
            if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
                checks++;
                if (expq.size() == 0 || upd_pc !== expq[0]) begin
                    errors++;
                    $display("FAIL stream_order got pc=%h want %h (rec %0d)",
                             upd_pc, (expq.size() != 0) ? expq[0] : 31'h0, got);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                got++;
            end
            step();
            cyc++;
        end
        br_valid = 1'b0;
        commit = 1'b0;
        upd_ready = 1'b0;
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL stream_count got %0d want 20 (cycles %0d)", got, cyc);
        end
        checks++;
        if (upd_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got v=%b o=%b want 0 0", upd_valid, ovf);
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        for (int i = 0; i < 5; i++) enq(31'h70 + 31'(i));
        commit = 1'b1;
        step();
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b1 || ovf !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL mr_pre got v=%b o=%b f=%b want 1 1 1",
                     upd_valid, ovf, full);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (upd_valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mr_post got v=%b f=%b o=%b want 0 0 0",
                     upd_valid, full, ovf);
        end
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_gone got v=%b want 0", upd_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        br_valid = 1'b0;
        br_pc = '0;
        br_ataken = 1'b0;
        br_misp = 1'b0;
        br_hist = '0;
        br_target = '0;
        commit = 1'b0;
        flush_lower = 1'b0;
        upd_ready = 1'b0;
        test_reset();
        test_single();
        test_full_ovf();
        test_flush();
        test_commit_flush();
        test_full_deq_enq();
        test_stream_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_bp_update_queue.md
# exu_bp_update_queue

Branch-predictor update queue downstream of the EXU ALU control stage. It captures each resolved branch record (PC, actual direction, mispredict, new 2-bit history, target) in the cycle the ALU resolves it. Each record is held as speculative until the commit pipeline retires it, or is discarded on a lower flush. Committed records drain in order to the BTB/BHT write port through a valid/ready handshake, so predictor write-port conflicts never stall branch resolution.

## Interface
Parameters:
- DEPTH, 4, number of record slots; power of two, ≥2
- PTRW, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- br_valid  in  1  resolved branch this cycle (ALU valid_ff & branch/jal)
- br_pc  in  31  pc_ff[31:1] of the branch
- br_ataken  in  1  actual taken
- br_misp  in  1  mispredict (cond or target)
- br_hist  in  2  updated 2-bit counter
- br_target  in  31  resolved target [31:1]
- commit  in  1  oldest speculative record retired this cycle
- flush_lower  in  1  kill all speculative records
- upd_valid  out  1  committed record presented
- upd_ready  in  1  predictor accepts record
- upd_pc, upd_target  out  31  head record fields
- upd_ataken, upd_misp  out  1  head record fields
- upd_hist  out  2  head record field
- full  out  1  count==DEPTH; used by decode to freeze
- ovf  out  1  sticky: a record was dropped while full

## Operation
- Circular buffer; three registered pointers wr_ptr, cm_ptr, rd_ptr (PTRW+1 bits, MSB is wrap bit). Order is rd ≤ cm ≤ wr.
- Committed region [rd,cm) is eligible for drain. Speculative region [cm,wr) is awaiting retire.
- Enqueue: br_valid & ~flush_lower & (~full | deq) writes slot wr_ptr, then wr_ptr+1.
- Dequeue (deq) = upd_valid & upd_ready; rd_ptr+1.
- Commit: commit & (cm≠wr) → cm_ptr+1. Commit with no speculative record is ignored.
- flush_lower: wr_ptr ← cm_ptr after any same-cycle commit (commit first, then flush). The same-cycle br_valid record is dropped and ovf is not set.
- Drop: br_valid & ~flush_lower & full & ~deq → record discarded, ovf←1. ovf is cleared only by rst.
- upd_valid = (rd≠cm). upd_* = slot[rd] fields, combinational from storage. Outputs are undefined-but-stable when upd_valid=0.
- Record contents never change while in the queue.

## Timing
- Reset: all pointers 0; upd_valid=0, full=0, ovf=0. Storage is not reset.
- Reset mid-operation discards all records, committed ones included.
- Enqueue→commit: the record is visible as speculative the cycle after enqueue. A commit may target it in that cycle at the earliest.
- Commit→upd_valid: 1 cycle (registered cm_ptr).
- Minimum enqueue→upd_valid latency: 2 cycles.
- Dequeue throughput: 1 record/cycle. upd_ready may be asserted without upd_valid (no effect).
- Full with simultaneous deq and enqueue: accepted, count unchanged, full stays 1.
- Wrap-around: pointers wrap mod 2·DEPTH. full = (wr[PTRW]≠rd[PTRW]) & (wr[PTRW-1:0]==rd[PTRW-1:0]).
- Commit and flush_lower never reclaim committed records. Dequeue is never blocked by flush.

## Structure
- Shared package swerv_types gains bp_upd_pkt_t {pc[31:1], target[31:1], ataken, misp, hist[1:0]}. Storage and upd_* outputs are built from this typedef.
- Storage is DEPTH rvdffe instances of $bits(bp_upd_pkt_t), enabled per-slot on enqueue. Pointers use rvdff with synchronous reset.
- One natural sub-module: exu_bp_upd_ptr, a PTRW+1 pointer with increment, load (for flush) and sync reset, instantiated three times.

## Test plan
- Single branch pc=0x100 enqueued, commit 1 cycle later → upd_valid high 1 cycle after commit, upd_pc=0x100; upd_ready=1 → upd_valid drops next cycle.
- Enqueue 4 records, no commit → full=1, upd_valid=0. A 5th br_valid sets ovf=1 and the record is dropped. Commit ×4 → 4 records drain in order with ready held.
- Enqueue A,B,C; commit A; flush_lower same cycle as enqueue D → only A drains. B, C and D are gone; wr_ptr==cm_ptr.
- Commit and flush_lower in the same cycle with speculative B,C → B committed and drained; C killed.
- Full queue, upd_ready=1 with br_valid in the same cycle → record accepted, full stays 1, ovf stays 0.
- 20 records streamed with commit each cycle and ready toggling → order preserved across pointer wrap. rst asserted mid-stream → upd_valid=0, full=0, ovf=0 next cycle.
